dark_counter: RTL and testbench

DARK_COUNTER -- requirements
Module: dark_counter

---
 rtl/dark_pkg.sv | 16 +
 rtl/dark_window.sv | 50 +++++
 rtl/dark_counter.sv | 147 ++++++++++++++
 tb/tb_dark_counter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dark_pkg.sv
// Shared constants and FSM state type for the dark-pixel counter.
package dark_pkg;

    localparam int unsigned DATA_W_DEF  = 12;
    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned FRAME_W_DEF = 640;
    localparam int unsigned WIN_W       = 16;
    localparam int unsigned THR_RST_VAL = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } darkState_t;

endpackage

// File: rtl/dark_window.sv
// Pixel position tracker and inclusive window compare (used with DARK_CNT_WINDOW_EN).
module dark_window
    import dark_pkg::*;
#(
    parameter int unsigned FRAME_W = FRAME_W_DEF
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iFrameStart,
    input  logic             iPixValid,
    input  logic [WIN_W-1:0] iWinX0,
    input  logic [WIN_W-1:0] iWinX1,
    input  logic [WIN_W-1:0] iWinY0,
    input  logic [WIN_W-1:0] iWinY1,
    output logic             oInWin_c
);

    logic [WIN_W-1:0] xCnt;
    logic [WIN_W-1:0] yCnt;
    logic [WIN_W-1:0] xCur;
    logic [WIN_W-1:0] yCur;

    // Position of the current pixel; the first pixel of a frame sits at (0,0).
    always_comb begin
        xCur     = iFrameStart ? '0 : xCnt;
        yCur     = iFrameStart ? '0 : yCnt;
        oInWin_c = (xCur >= iWinX0) && (xCur <= iWinX1) &&
                   (yCur >= iWinY0) && (yCur <= iWinY1);
    end

    // Advance position per valid pixel, wrapping X at end of line.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            xCnt <= '0;
            yCnt <= '0;
        end else if (iPixValid) begin
            if (xCur == WIN_W'(FRAME_W - 1)) begin
                xCnt <= '0;
                yCnt <= yCur + WIN_W'(1);
            end else begin
                xCnt <= xCur + WIN_W'(1);
                yCnt <= yCur;
            end
        end else if (iFrameStart) begin
            xCnt <= '0;
            yCnt <= '0;
        end
    end

endmodule

// File: rtl/dark_counter.sv
// Per-frame dark-pixel counter with saturating accumulator.
// Optional window restriction enabled by defining DARK_CNT_WINDOW_EN.
module dark_counter
    import dark_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
`ifdef DARK_CNT_WINDOW_EN
    parameter int unsigned FRAME_W = FRAME_W_DEF,
`endif
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iFVAL,
    input  logic              iDVAL,
    input  logic [DATA_W-1:0] iDATA,
    input  logic [DATA_W-1:0] iThreshold,
`ifdef DARK_CNT_WINDOW_EN
    input  logic [WIN_W-1:0]  iWinX0,
    input  logic [WIN_W-1:0]  iWinX1,
    input  logic [WIN_W-1:0]  iWinY0,
    input  logic [WIN_W-1:0]  iWinY1,
`endif
    output logic [CNT_W-1:0]  oDarkCounter,
    output logic              oCountValid,
    output logic              oSaturated
);

    darkState_t        state;
    darkState_t        stateNext;
    logic              fvalPrev;
    logic              armed;
    logic [DATA_W-1:0] thrLatch;
    logic [DATA_W-1:0] thrNext;
    logic [CNT_W-1:0]  acc;
    logic [CNT_W-1:0]  accNext;
    logic              satFlag;
    logic              satNext;
    logic [CNT_W-1:0]  cntNext;
    logic              validNext;
    logic              satOutNext;
    logic              rise_c;
    logic              fall_c;
    logic              frameStart_c;
    logic              inWin_c;
    logic              startDark_c;
    logic              runDark_c;

    // Edge detect; armed blocks a frame already in progress when reset released.
    assign rise_c       = iFVAL & ~fvalPrev & armed;
    assign fall_c       = ~iFVAL & fvalPrev;
    assign frameStart_c = ((state == IDLE) & rise_c) | ((state == DONE) & iFVAL);

`ifdef DARK_CNT_WINDOW_EN
    dark_window #(
        .FRAME_W    (FRAME_W)
    ) uWindow (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iFrameStart(frameStart_c),
        .iPixValid  (iFVAL & iDVAL),
        .iWinX0     (iWinX0),
        .iWinX1     (iWinX1),
        .iWinY0     (iWinY0),
        .iWinY1     (iWinY1),
        .oInWin_c   (inWin_c)
    );
`else
    assign inWin_c = 1'b1;
`endif

    // The frame's first pixel uses the live threshold, later pixels the latched one.
    assign startDark_c = iFVAL & iDVAL & inWin_c & (iDATA < iThreshold);
    assign runDark_c   = iFVAL & iDVAL & inWin_c & (iDATA < thrLatch);

    // State, accumulator and output registers.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state        <= IDLE;
            fvalPrev     <= 1'b0;
            armed        <= 1'b0;
            thrLatch     <= DATA_W'(THR_RST_VAL);
            acc          <= '0;
            satFlag      <= 1'b0;
            oDarkCounter <= '0;
            oCountValid  <= 1'b0;
            oSaturated   <= 1'b0;
        end else begin
            state        <= stateNext;
            fvalPrev     <= iFVAL;
            armed        <= armed | ~iFVAL;
            thrLatch     <= thrNext;
            acc          <= accNext;
            satFlag      <= satNext;
            oDarkCounter <= cntNext;
            oCountValid  <= validNext;
            oSaturated   <= satOutNext;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        stateNext  = state;
        thrNext    = thrLatch;
        accNext    = acc;
        satNext    = satFlag;
        cntNext    = oDarkCounter;
        validNext  = 1'b0;
        satOutNext = oSaturated;
        unique case (state)
            IDLE: begin
                if (frameStart_c) begin
                    stateNext = COUNT;
                    thrNext   = iThreshold;
                    accNext   = CNT_W'(startDark_c);
                    satNext   = 1'b0;
                end
            end
            COUNT: begin
                if (fall_c) begin
                    stateNext = DONE;
                end else if (runDark_c) begin
                    if (&acc) begin
                        satNext = 1'b1;
                    end else begin
                        accNext = acc + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                cntNext    = acc;
                validNext  = 1'b1;
                satOutNext = satFlag;
                if (frameStart_c) begin
                    stateNext = COUNT;
                    thrNext   = iThreshold;
                    accNext   = CNT_W'(startDark_c);
                    satNext   = 1'b0;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dark_counter.sv
// Self-checking bench for dark_counter; window tests run when DARK_CNT_WINDOW_EN is defined.
module tb_dark_counter;

    localparam int unsigned DATA_W  = 12;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned FRAME_W = 640;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic              iCLK = 1'b0;
    logic              iRST;
    logic              iFVAL;
    logic              iDVAL;
    logic [DATA_W-1:0] iDATA;
    logic [DATA_W-1:0] iThreshold;
    logic [15:0]       iWinX0, iWinX1, iWinY0, iWinY1;
    logic [CNT_W-1:0]  oDarkCounter;
    logic              oCountValid;
    logic              oSaturated;

    int passCnt  = 0;
    int totalCnt = 0;

    always #5 iCLK = ~iCLK;

    dark_counter #(
        .DATA_W      (DATA_W),
`ifdef DARK_CNT_WINDOW_EN
        .FRAME_W     (FRAME_W),
`endif
        .CNT_W       (CNT_W)
    ) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iFVAL       (iFVAL),
        .iDVAL       (iDVAL),
        .iDATA       (iDATA),
        .iThreshold  (iThreshold),
`ifdef DARK_CNT_WINDOW_EN
        .iWinX0      (iWinX0),
        .iWinX1      (iWinX1),
        .iWinY0      (iWinY0),
        .iWinY1      (iWinY1),
`endif
        .oDarkCounter(oDarkCounter),
        .oCountValid (oCountValid),
        .oSaturated  (oSaturated)
    );

    task automatic chk(input string nm, input int act, input int exp);
        totalCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    endtask

    // Reference model: frame-level behaviour with an unclipped integer count.
    bit mPrev, mArmed, mActive, mPend;
    int mCnt, mThr, mX, mY;
    int expCount, expSat, expValid;

    function automatic bit inWin(input int x, input int y);
`ifdef DARK_CNT_WINDOW_EN
        return (x >= int'(iWinX0)) && (x <= int'(iWinX1)) &&
               (y >= int'(iWinY0)) && (y <= int'(iWinY1));
`else
        return 1'b1;
`endif
    endfunction

    task automatic mPixel();
        if (iFVAL && iDVAL) begin
            if ((int'(iDATA) < mThr) && inWin(mX, mY)) mCnt++;
            mX++;
            if (mX == int'(FRAME_W)) begin
                mX = 0;
                mY++;
            end
        end
    endtask

    always @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            mPrev = 0; mArmed = 0; mActive = 0; mPend = 0;
            mCnt = 0; mThr = 0; mX = 0; mY = 0;
            expCount = 0; expSat = 0; expValid = 0;
        end else begin
            expValid = 0;
            if (mPend) begin
                expValid = 1;
                expCount = (mCnt > CNT_MAX) ? CNT_MAX : mCnt;
                expSat   = (mCnt > CNT_MAX) ? 1 : 0;
                mPend    = 0;
            end
            if (mActive && !iFVAL) begin
                mActive = 0;
                mPend   = 1;
            end else if (!mActive && iFVAL && !mPrev && mArmed) begin
                mActive = 1;
                mThr    = int'(iThreshold);
                mCnt    = 0;
                mX      = 0;
                mY      = 0;
                mPixel();
            end else if (mActive) begin
                mPixel();
            end
            if (!iFVAL) mArmed = 1;
            mPrev = iFVAL;
        end
    end

    // Per-cycle compare against the model, sampled on the falling edge.
    int validCnt  = 0;
    int lastCount = -1;
    int lastSat   = -1;
    always @(negedge iCLK) begin
        chk("valid", int'(oCountValid), expValid);
        chk("count", int'(oDarkCounter), expCount);
        chk("sat",   int'(oSaturated), expSat);
        if (oCountValid) begin
            validCnt++;
            lastCount = int'(oDarkCounter);
            lastSat   = int'(oSaturated);
        end
    end

    task automatic pix(input int n, input logic [DATA_W-1:0] d);
        for (int i = 0; i < n; i++) begin
            @(negedge iCLK);
            iFVAL = 1'b1; iDVAL = 1'b1; iDATA = d;
        end
    endtask

    // Gaps drive dark-looking pixels with iDVAL high; they must be ignored.
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge iCLK);
            iFVAL = 1'b0; iDVAL = 1'b1; iDATA = '0;
        end
    endtask

    task automatic frameResult(input string nm, input int v0, input int cnt, input int sat);
        chk({nm, "_strobes"}, validCnt - v0, 1);
        chk({nm, "_count"}, lastCount, cnt);
        chk({nm, "_sat"}, lastSat, sat);
        chk({nm, "_model"}, expCount, cnt);
    endtask

    initial begin
        int v0;
        iRST = 1'b1; iFVAL = 1'b0; iDVAL = 1'b0; iDATA = '0; iThreshold = '0;
        iWinX0 = 16'h0000; iWinX1 = 16'hFFFF; iWinY0 = 16'h0000; iWinY1 = 16'hFFFF;
        #1;
        chk("rst_count", int'(oDarkCounter), 0);
        chk("rst_valid", int'(oCountValid), 0);
        chk("rst_sat", int'(oSaturated), 0);
        repeat (3) @(negedge iCLK);
        iRST = 1'b0;
        gap(3);

        // 40 dark of 100, mixed ordering
        iThreshold = 12'h100;
        v0 = validCnt;
        pix(40, 12'h010); pix(60, 12'h200); gap(4);
        frameResult("basic", v0, 40, 0);

        // Equality is not dark
        v0 = validCnt;
        pix(50, 12'h100); pix(50, 12'h0FF); gap(4);
        frameResult("equal", v0, 50, 0);

        // Mid-frame threshold change ignored; next frame picks it up
        v0 = validCnt;
        iThreshold = 12'h100;
        pix(10, 12'h010);
        iThreshold = 12'hFFF;
        pix(10, 12'h200); gap(4);
        frameResult("thr_hold", v0, 10, 0);
        v0 = validCnt;
        pix(10, 12'h200); gap(4);
        frameResult("thr_next", v0, 10, 0);

        // Saturation, then recovery on the next frame
        iThreshold = 12'h100;
        v0 = validCnt;
        pix(70000, 12'h000); gap(4);
        frameResult("satur", v0, CNT_MAX, 1);
        v0 = validCnt;
        pix(5, 12'h000); pix(5, 12'h300); gap(4);
        frameResult("after_sat", v0, 5, 0);

        // Reset mid-frame after 30 dark pixels
        v0 = validCnt;
        pix(30, 12'h000);
        #2 iRST = 1'b1;
        #1;
        chk("mid_rst_count", int'(oDarkCounter), 0);
        chk("mid_rst_valid", int'(oCountValid), 0);
        chk("mid_rst_sat", int'(oSaturated), 0);
        pix(2, 12'h000);
        iRST = 1'b0;
        pix(10, 12'h000); gap(4);
        chk("mid_rst_no_strobe", validCnt - v0, 0);
        iThreshold = 12'h100;
        v0 = validCnt;
        pix(10, 12'h000); gap(4);
        frameResult("post_rst", v0, 10, 0);

        // Random frames; one-cycle gaps re-rise in the DONE cycle
        for (int f = 0; f < 10; f++) begin
            int n;
            iThreshold = DATA_W'($urandom);
            n = $urandom_range(20, 200);
            for (int i = 0; i < n; i++) begin
                @(negedge iCLK);
                iFVAL = 1'b1;
                iDVAL = ($urandom_range(0, 3) != 0);
                iDATA = DATA_W'($urandom);
                if ($urandom_range(0, 19) == 0) iThreshold = DATA_W'($urandom);
            end
            gap($urandom_range(1, 3));
        end
        gap(4);

`ifdef DARK_CNT_WINDOW_EN
        // Window 10..19 x 5..6 over full-size all-dark frames, back to back
        iWinX0 = 16'd10; iWinX1 = 16'd19; iWinY0 = 16'd5; iWinY1 = 16'd6;
        iThreshold = 12'h100;
        v0 = validCnt;
        pix(FRAME_W * 8, 12'h000); gap(1);
        pix(FRAME_W * 7, 12'h000); gap(4);
        chk("win_strobes", validCnt - v0, 2);
        chk("win_count", lastCount, 20);
        chk("win_model", expCount, 20);
        iWinX0 = 16'h0000; iWinX1 = 16'hFFFF; iWinY0 = 16'h0000; iWinY1 = 16'hFFFF;
`endif

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
